// File: rtl/l2_sched_pkg.sv
// Shared types for the L2 port scheduler: requester ids, FSM states, requester count.
// Combinational helpers only; no state lives here.
// No handshake of its own; consumers apply backpressure by holding requests.
package l2_sched_pkg;

  localparam int NUM_REQ = 3;

  typedef enum logic [1:0] {
    REQ_DC = 2'd0,
    REQ_IC = 2'd1,
    REQ_PF = 2'd2
  } req_id_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_RD = 2'd1,
    BUSY_WR = 2'd2,
    DONE    = 2'd3
  } sched_state_e;

  // Map a one-hot grant vector to the requester id (bit 0 = dcache).
  function automatic req_id_e grant_to_id(input logic [NUM_REQ-1:0] grant);
    if (grant[1]) return REQ_IC;
    if (grant[2]) return REQ_PF;
    return REQ_DC;
  endfunction

endpackage

// File: rtl/l2_sched_pick.sv
// Picks one requester: starved requesters first, then fixed order dc > ic > pf.
// Purely combinational, zero latency.
// No backpressure; an empty pending vector yields an all-zero grant.
module l2_sched_pick
  import l2_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [NUM_REQ-1:0] starved_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic [NUM_REQ-1:0] cand;

  // Restrict to starved requesters when any exist, then take the lowest index.
  always_comb begin
    cand    = (|starved_i) ? starved_i : pending_i;
    grant_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant_o    = '0;
        grant_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l2_port_scheduler.sv
// Shares one L2 port among dcache, icache and prefetcher; one transaction in flight.
// Latency: request in IDLE cycle 0 -> L2 command cycle 1 -> owner resp one cycle after l2_resp.
// Requesters hold level requests until their resp pulse; L2 holds off by delaying l2_resp.
module l2_port_scheduler
  import l2_sched_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dc_read,
  input  logic              dc_write,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              dc_resp,
  input  logic              ic_read,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [LINE_W-1:0] ic_rdata,
  output logic              ic_resp,
  input  logic              pf_read,
  input  logic [ADDR_W-1:0] pf_addr,
  output logic [LINE_W-1:0] pf_rdata,
  output logic              pf_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  localparam int               AGE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_MAX);

  sched_state_e       state_q, state_d;
  req_id_e            owner_q, owner_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  dc_rdata_q, dc_rdata_d;
  logic [LINE_W-1:0]  ic_rdata_q, ic_rdata_d;
  logic [LINE_W-1:0]  pf_rdata_q, pf_rdata_d;
  logic [AGE_W-1:0]   age_q [NUM_REQ];
  logic [AGE_W-1:0]   age_d [NUM_REQ];

  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] starved;
  logic [NUM_REQ-1:0] grant;
  logic               win;

  // A dcache read+write pair counts as one pending dcache request (served as the write).
  assign pending = {pf_read, ic_read, dc_read | dc_write};
  assign win     = (state_q == IDLE) && (|grant);

  // Starvation flags from the saturating age counters.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      starved[i] = pending[i] && (age_q[i] == AGE_MAX);
    end
  end

  l2_sched_pick u_pick (
    .pending_i (pending),
    .starved_i (starved),
    .grant_o   (grant)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: writeback takes precedence over a simultaneous dcache read.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:             if (|grant) state_d = (grant[0] && dc_write) ? BUSY_WR : BUSY_RD;
      BUSY_RD, BUSY_WR: if (l2_resp) state_d = DONE;
      DONE:             state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  // Output decode from registered state and latched transaction fields.
  always_comb begin
    l2_read  = (state_q == BUSY_RD);
    l2_write = (state_q == BUSY_WR);
    l2_addr  = addr_q;
    l2_wdata = wdata_q;
    dc_resp  = (state_q == DONE) && (owner_q == REQ_DC);
    ic_resp  = (state_q == DONE) && (owner_q == REQ_IC);
    pf_resp  = (state_q == DONE) && (owner_q == REQ_PF);
    dc_rdata = dc_rdata_q;
    ic_rdata = ic_rdata_q;
    pf_rdata = pf_rdata_q;
  end

  // Datapath next-state: latch the winner, age the losers, capture read fill for the owner.
  always_comb begin
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dc_rdata_d = dc_rdata_q;
    ic_rdata_d = ic_rdata_q;
    pf_rdata_d = pf_rdata_q;
    for (int i = 0; i < NUM_REQ; i++) age_d[i] = age_q[i];

    if (win) begin
      owner_d = grant_to_id(grant);
      case (grant_to_id(grant))
        REQ_IC:  addr_d = ic_addr;
        REQ_PF:  addr_d = pf_addr;
        default: addr_d = dc_addr;
      endcase
      if (grant[0] && dc_write) wdata_d = dc_wdata;
    end

    // Ages only move on arbitration cycles; a requester not asking in IDLE loses its history.
    if (state_q == IDLE) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] || !pending[i])          age_d[i] = '0;
        else if (win && age_q[i] != AGE_MAX) age_d[i] = age_q[i] + AGE_W'(1);
      end
    end

    // Write completions carry no fill data, so no rdata register changes.
    if (state_q == BUSY_RD && l2_resp) begin
      case (owner_q)
        REQ_IC:  ic_rdata_d = l2_rdata;
        REQ_PF:  pf_rdata_d = l2_rdata;
        default: dc_rdata_d = l2_rdata;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q    <= REQ_DC;
      addr_q     <= '0;
      wdata_q    <= '0;
      dc_rdata_q <= '0;
      ic_rdata_q <= '0;
      pf_rdata_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= '0;
    end else begin
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dc_rdata_q <= dc_rdata_d;
      ic_rdata_q <= ic_rdata_d;
      pf_rdata_q <= pf_rdata_d;
      for (int i = 0; i < NUM_REQ; i++) age_q[i] <= age_d[i];
    end
  end

endmodule

// File: tb/tb_l2_port_scheduler.sv
// Directed bench for the L2 port scheduler with hand-computed expected values.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// The bench plays the L2 side by hand, choosing when l2_resp fires.
module tb_l2_port_scheduler;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              dc_read = 1'b0, dc_write = 1'b0;
  logic [ADDR_W-1:0] dc_addr = '0;
  logic [LINE_W-1:0] dc_wdata = '0;
  logic [LINE_W-1:0] dc_rdata;
  logic              dc_resp;
  logic              ic_read = 1'b0;
  logic [ADDR_W-1:0] ic_addr = '0;
  logic [LINE_W-1:0] ic_rdata;
  logic              ic_resp;
  logic              pf_read = 1'b0;
  logic [ADDR_W-1:0] pf_addr = '0;
  logic [LINE_W-1:0] pf_rdata;
  logic              pf_resp;
  logic              l2_read, l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata = '0;
  logic              l2_resp = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [LINE_W-1:0] exp_dc = '0, exp_ic = '0, exp_pf = '0;

  l2_port_scheduler #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_resp(dc_resp),
    .ic_read(ic_read), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_resp(ic_resp),
    .pf_read(pf_read), .pf_addr(pf_addr), .pf_rdata(pf_rdata), .pf_resp(pf_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mask bits: 0 dc_read, 1 dc_write, 2 ic_read, 3 pf_read.
  task automatic drop(input logic [3:0] m);
    if (m[0]) dc_read  = 1'b0;
    if (m[1]) dc_write = 1'b0;
    if (m[2]) ic_read  = 1'b0;
    if (m[3]) pf_read  = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".l2rd"}, l2_read, 1'b0);
    chk({tag, ".l2wr"}, l2_write, 1'b0);
    chk({tag, ".resp"}, {dc_resp, ic_resp, pf_resp}, 3'b000);
    chk({tag, ".dcrd"}, dc_rdata, exp_dc);
    chk({tag, ".icrd"}, ic_rdata, exp_ic);
    chk({tag, ".pfrd"}, pf_rdata, exp_pf);
  endtask

  // Called in an IDLE cycle with requests already driven; returns in the next IDLE cycle.
  // owner: 0 dc, 1 ic, 2 pf.
  task automatic run_txn(input string tag, input logic [ADDR_W-1:0] exp_addr, input logic exp_wr,
                         input logic [LINE_W-1:0] exp_wdata, input int owner, input int lat,
                         input logic [LINE_W-1:0] rdata, input logic [3:0] drop_cmd,
                         input logic [3:0] drop_done);
    tick();
    drop(drop_cmd);
    for (int c = 1; c <= lat; c++) begin
      chk({tag, ".l2rd"}, l2_read, !exp_wr);
      chk({tag, ".l2wr"}, l2_write, exp_wr);
      chk({tag, ".addr"}, l2_addr, exp_addr);
      if (exp_wr) chk({tag, ".wdat"}, l2_wdata, exp_wdata);
      chk({tag, ".busyresp"}, {dc_resp, ic_resp, pf_resp}, 3'b000);
      if (c == lat) begin
        l2_resp  = 1'b1;
        l2_rdata = rdata;
      end
      tick();
    end
    l2_resp  = 1'b0;
    l2_rdata = '0;
    if (!exp_wr) begin
      if (owner == 0) exp_dc = rdata;
      if (owner == 1) exp_ic = rdata;
      if (owner == 2) exp_pf = rdata;
    end
    chk({tag, ".done.resp"}, {dc_resp, ic_resp, pf_resp},
        {owner == 0, owner == 1, owner == 2});
    chk({tag, ".done.l2cmd"}, {l2_read, l2_write}, 2'b00);
    chk({tag, ".done.dcrd"}, dc_rdata, exp_dc);
    chk({tag, ".done.icrd"}, ic_rdata, exp_ic);
    chk({tag, ".done.pfrd"}, pf_rdata, exp_pf);
    drop(drop_done);
    tick();
    chk({tag, ".idle.resp"}, {dc_resp, ic_resp, pf_resp}, 3'b000);
  endtask

  initial begin
    logic [LINE_W-1:0] pat;

    // Reset values
    #2;
    chk_quiet("rst");
    chk("rst.addr", l2_addr, '0);
    chk("rst.wdata", l2_wdata, '0);
    tick();
    rst_n = 1'b1;

    // 1: single dcache read, L2 answers in the third command cycle
    dc_read = 1'b1;
    dc_addr = 32'h100;
    run_txn("t1", 32'h100, 1'b0, '0, 0, 3, {8{32'hA1A1_0001}}, 4'b0000, 4'b0001);
    chk_quiet("t1.idle");

    // 2: all three at once -> dc, ic, pf
    dc_read = 1'b1; dc_addr = 32'h200;
    ic_read = 1'b1; ic_addr = 32'h300;
    pf_read = 1'b1; pf_addr = 32'h400;
    run_txn("t2.dc", 32'h200, 1'b0, '0, 0, 1, {8{32'hB2B2_0001}}, 4'b0000, 4'b0001);
    run_txn("t2.ic", 32'h300, 1'b0, '0, 1, 2, {8{32'hB2B2_0002}}, 4'b0000, 4'b0100);
    run_txn("t2.pf", 32'h400, 1'b0, '0, 2, 1, {8{32'hB2B2_0003}}, 4'b0000, 4'b1000);
    chk_quiet("t2.idle");

    // 3: dcache toggling back-to-back starves the held prefetch after four grants
    dc_addr = 32'h500;
    pf_read = 1'b1; pf_addr = 32'h600;
    for (int i = 0; i < 4; i++) begin
      dc_read = 1'b1;
      run_txn($sformatf("t3.dc%0d", i), 32'h500, 1'b0, '0, 0, 1,
              {8{32'hC300_0000 + 32'(i)}}, 4'b0000, 4'b0001);
    end
    dc_read = 1'b1;
    run_txn("t3.pf", 32'h600, 1'b0, '0, 2, 1, {8{32'hC3FF_0000}}, 4'b0000, 4'b1000);
    run_txn("t3.dc4", 32'h500, 1'b0, '0, 0, 1, {8{32'hC300_0004}}, 4'b0000, 4'b0001);
    chk_quiet("t3.idle");

    // 4: writeback with a read raised alongside -> write first, dc_rdata untouched, then the read
    pat = {8{32'h5A5A_F00D}};
    dc_read = 1'b1; dc_write = 1'b1;
    dc_addr = 32'h2A0; dc_wdata = pat;
    run_txn("t4.wr", 32'h2A0, 1'b1, pat, 0, 3, {8{32'hDEAD_BEEF}}, 4'b0000, 4'b0010);
    run_txn("t4.rd", 32'h2A0, 1'b0, '0, 0, 1, {8{32'hD4D4_0001}}, 4'b0000, 4'b0001);
    chk_quiet("t4.idle");

    // 5: reset in the middle of a read abandons it
    ic_read = 1'b1; ic_addr = 32'h700;
    tick();
    chk("t5.cmd", l2_read, 1'b1);
    tick();
    rst_n = 1'b0;
    exp_dc = '0; exp_ic = '0; exp_pf = '0;
    #1;
    chk_quiet("t5.rst");
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_quiet("t5.hold");
    end
    rst_n = 1'b1;
    run_txn("t5.ic", 32'h700, 1'b0, '0, 1, 2, {8{32'hE5E5_0001}}, 4'b0000, 4'b0100);
    chk_quiet("t5.idle");

    // 6: prefetch withdrawn as dcache wins, then a stray L2 completion in IDLE
    dc_read = 1'b1; dc_addr = 32'h800;
    pf_read = 1'b1; pf_addr = 32'h900;
    run_txn("t6.dc", 32'h800, 1'b0, '0, 0, 1, {8{32'hF6F6_0001}}, 4'b1000, 4'b0001);
    l2_resp  = 1'b1;
    l2_rdata = {8{32'h0BAD_0BAD}};
    tick();
    l2_resp  = 1'b0;
    l2_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      chk_quiet("t6.stray");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
